// File: rtl/fp32_mul_seq.sv
// fp32_mul_seq
//   Sequential IEEE-754 single-precision multiplier. It accepts one operand
//   pair per in_valid/in_ready handshake and builds the 48-bit mantissa product
//   by shift-add, consuming BITS_PER_CYCLE multiplier bits per cycle. It then
//   normalizes the product, truncating toward zero, and presents the packed
//   result on an out_valid/out_ready handshake. Denormals are flushed to zero.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid, in_ready  operand handshake (in_ready is registered)
//   a, b                FP32 operands
//   out_valid, out_ready result handshake
//   res                 FP32 product; held stable while out_valid=1
//   ovf                 result saturated to infinity
//   unf                 result flushed to signed zero by exponent underflow
//   inv                 invalid operation (NaN operand or inf*0), res=0x7FC00000
module fp32_mul_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        ovf,
  output logic        unf,
  output logic        inv
);

  localparam int unsigned ITERS = 24 / BITS_PER_CYCLE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               sign_q;
  logic               special_q;
  logic signed [9:0]  e_q;
  logic [47:0]        ma_sh;
  logic [23:0]        mb_sh;
  logic [47:0]        acc;
  logic [4:0]         cnt;

  // Operand classification
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic [9:0]         e_sum;
  // Multiply step and normalization
  logic [47:0]        pp;
  logic signed [9:0]  e_n;
  logic [22:0]        frac_n;

  always_comb begin
    a_zero = (a_q[30:23] == 8'd0);
    b_zero = (b_q[30:23] == 8'd0);
    a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    sgn    = a_q[31] ^ b_q[31];
    // Two's-complement wrap in 10 bits gives the signed biased exponent.
    e_sum  = {2'b00, a_q[30:23]} + {2'b00, b_q[30:23]} - 10'd127;
  end

  always_comb begin
    pp = ma_sh * 48'(mb_sh[BITS_PER_CYCLE-1:0]);
  end

  always_comb begin
    e_n    = acc[47] ? (e_q + 10'sd1) : e_q;
    frac_n = acc[47] ? 23'(acc >> 24) : 23'(acc >> 23);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inv       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      e_q       <= '0;
      ma_sh     <= '0;
      mb_sh     <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            in_ready <= 1'b0;
            state    <= S_UNPACK;
          end
        end

        // Special results are written here but still pass through NORM, so
        // they appear two edges after accept rather than one.
        S_UNPACK: begin
          sign_q    <= sgn;
          special_q <= 1'b1;
          state     <= S_NORM;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            res <= 32'h7FC0_0000;
            inv <= 1'b1;
          end else if (a_inf || b_inf) begin
            res <= {sgn, 8'hFF, 23'd0};
          end else if (a_zero || b_zero) begin
            res <= {sgn, 31'd0};
          end else begin
            special_q <= 1'b0;
            ma_sh     <= {24'd0, 1'b1, a_q[22:0]};
            mb_sh     <= {1'b1, b_q[22:0]};
            e_q       <= e_sum;
            acc       <= '0;
            cnt       <= '0;
            state     <= S_MUL;
          end
        end

        // Shifting ma left each step is equivalent to shifting the partial
        // product by cnt*BITS_PER_CYCLE.
        S_MUL: begin
          acc   <= acc + pp;
          ma_sh <= ma_sh << BITS_PER_CYCLE;
          mb_sh <= mb_sh >> BITS_PER_CYCLE;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'(ITERS - 1))
            state <= S_NORM;
        end

        S_NORM: begin
          if (!special_q) begin
            if (e_n >= 10'sd255) begin
              res <= {sign_q, 8'hFF, 23'd0};
              ovf <= 1'b1;
            end else if (e_n <= 10'sd0) begin
              res <= {sign_q, 31'd0};
              unf <= 1'b1;
            end else begin
              res <= {sign_q, e_n[7:0], frac_n};
            end
          end
          out_valid <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            inv       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// tb_fp32_mul_seq
//   Directed self-checking bench for fp32_mul_seq. It drives one instance with
//   BITS_PER_CYCLE=1 and a second with BITS_PER_CYCLE=4. Expected values are
//   hand-computed constants.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, ovf, unf, inv;
  logic [31:0] res;

  logic        in_valid_4, out_ready_4;
  logic [31:0] a_4, b_4;
  logic        in_ready_4, out_valid_4, ovf_4, unf_4, inv_4;
  logic [31:0] res_4;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fp32_mul_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf), .unf(unf), .inv(inv)
  );

  fp32_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .a(a_4), .b(b_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
    .res(res_4), .ovf(ovf_4), .unf(unf_4), .inv(inv_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation on the BITS_PER_CYCLE=1 instance, check latency,
  // result and flags ({ovf,unf,inv}), then optionally retire it.
  task automatic run_op(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags, input bit retire);
    int lat;
    @(negedge clk);
    check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " res"}, res, exp_res);
    check({tag, " flags"}, 32'({ovf, unf, inv}), 32'(exp_flags));
    if (retire) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      check({tag, " retire_valid"}, 32'(out_valid), 32'd0);
      check({tag, " retire_ready"}, 32'(in_ready), 32'd1);
      check({tag, " retire_flags"}, 32'({ovf, unf, inv}), 32'd0);
      check({tag, " retire_res_kept"}, res, exp_res);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid_4 = 1'b0; out_ready_4 = 1'b0; a_4 = '0; b_4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset res", res, 32'h0);
    check("reset flags", 32'({ovf, unf, inv}), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("1.5*2", 32'h3FC0_0000, 32'h4000_0000, 26, 32'h4040_0000, 3'b000, 1'b1);
    run_op("1.5*1.5", 32'h3FC0_0000, 32'h3FC0_0000, 26, 32'h4010_0000, 3'b000, 1'b1);
    run_op("-2*3", 32'hC000_0000, 32'h4040_0000, 26, 32'hC0C0_0000, 3'b000, 1'b1);
    run_op("ovf", 32'h7F00_0000, 32'h7F00_0000, 26, 32'h7F80_0000, 3'b100, 1'b1);
    run_op("unf", 32'h0080_0000, 32'h0080_0000, 26, 32'h0000_0000, 3'b010, 1'b1);
    run_op("0*-3", 32'h0000_0000, 32'hC040_0000, 2, 32'h8000_0000, 3'b000, 1'b1);
    run_op("inf*0", 32'h7F80_0000, 32'h0000_0000, 2, 32'h7FC0_0000, 3'b001, 1'b1);
    run_op("nan", 32'h7FC0_0001, 32'h3F80_0000, 2, 32'h7FC0_0000, 3'b001, 1'b1);
    run_op("-inf*2", 32'hFF80_0000, 32'h4000_0000, 2, 32'hFF80_0000, 3'b000, 1'b1);

    // Backpressure: result held 10 cycles, in_valid pulses ignored.
    run_op("hold", 32'hC000_0000, 32'h4040_0000, 26, 32'hC0C0_0000, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = 32'h3F80_0000; b = 32'h3F80_0000;
      @(posedge clk); #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold res", res, 32'hC0C0_0000);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("hold retire_valid", 32'(out_valid), 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("hold no_ghost_result", 32'(out_valid), 32'd0);
    check("hold idle_ready", 32'(in_ready), 32'd1);

    // Reset during MUL cycle 10 discards the operation.
    @(negedge clk); a = 32'h3FC0_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst res", res, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("midrst no_result", 32'(out_valid), 32'd0);
    run_op("post_rst", 32'h3FC0_0000, 32'h4000_0000, 26, 32'h4040_0000, 3'b000, 1'b1);

    // BITS_PER_CYCLE=4 instance.
    @(negedge clk);
    check("bpc4 in_ready", 32'(in_ready_4), 32'd1);
    a_4 = 32'h3FC0_0000; b_4 = 32'h4000_0000; in_valid_4 = 1'b1;
    @(posedge clk); #1; in_valid_4 = 1'b0;
    lat = 0;
    while (!out_valid_4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bpc4 latency", 32'(lat), 32'd8);
    check("bpc4 res", res_4, 32'h4040_0000);
    check("bpc4 flags", 32'({ovf_4, unf_4, inv_4}), 32'd0);
    @(negedge clk); out_ready_4 = 1'b1;
    @(posedge clk); #1; out_ready_4 = 1'b0;
    @(negedge clk);
    a_4 = 32'h3FC0_0000; b_4 = 32'h3FC0_0000; in_valid_4 = 1'b1;
    @(posedge clk); #1; in_valid_4 = 1'b0;
    lat = 0;
    while (!out_valid_4 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bpc4 1.5*1.5 latency", 32'(lat), 32'd8);
    check("bpc4 1.5*1.5 res", res_4, 32'h4010_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
